// File: rtl/avmm_pio_master.sv
// avmm_pio_master: single-word Avalon-MM initiator for PIO-style slaves.
// Each accepted command becomes one bus access. Waitrequest stalls are honoured
// and bounded by a stall timeout. Reads use a fixed latency. Exactly one
// response strobe is returned per command.
// Optional feature: define AVMM_PIO_MASTER_VERIFY_EN to read back every
// completed write. The readback is compared under VERIFY_MASK.
module avmm_pio_master #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] VERIFY_MASK    = 32'h0000_00FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LAT_W    = 2;
  localparam int unsigned STALL_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned STALL_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned LAT_LAST   = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;

`ifdef AVMM_PIO_MASTER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RDWAIT, S_RESP, S_VRD, S_VWAIT
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RDWAIT, S_RESP
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic                chipselect_q, chipselect_d;
  logic                write_n_q, write_n_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                timeout_hit;

`ifndef AVMM_PIO_MASTER_VERIFY_EN
  // The mask only feeds the readback comparator.
  logic [DATA_W-1:0]   verify_mask_unused;
  assign verify_mask_unused = VERIFY_MASK;
`endif

  // Commands are only taken in IDLE and never while reset is asserted.
  assign cmd_ready      = (state_q == S_IDLE) && !reset;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;
  assign avm_address    = address_q;
  assign avm_chipselect = chipselect_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = writedata_q;

  // Next-state, bus-output and response computation.
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;
    stall_cnt_d  = stall_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    // A stall that would take the counter to the limit aborts; an unstalled
    // cycle at the same point completes normally.
    timeout_hit  = (TIMEOUT_CYCLES != 0) && avm_waitrequest &&
                   (stall_cnt_q == STALL_W'(STALL_LAST));

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          address_d    = cmd_addr;
          writedata_d  = cmd_wdata;
          stall_cnt_d  = '0;
          lat_cnt_d    = '0;
          chipselect_d = 1'b1;
          if (cmd_write) begin
            state_d   = S_WRITE;
            write_n_d = 1'b0;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_WRITE: begin
        if (!avm_waitrequest) begin
`ifdef AVMM_PIO_MASTER_VERIFY_EN
          state_d      = S_VRD;
          chipselect_d = 1'b1;
          stall_cnt_d  = '0;
`else
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
`endif
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          stall_cnt_d  = stall_cnt_q + STALL_W'(1);
          chipselect_d = 1'b1;
          write_n_d    = 1'b0;
        end
      end

      S_READ: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = avm_readdata;
            rsp_error_d = 1'b0;
          end else begin
            state_d   = S_RDWAIT;
            lat_cnt_d = '0;
          end
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          stall_cnt_d  = stall_cnt_q + STALL_W'(1);
          chipselect_d = 1'b1;
        end
      end

      S_RDWAIT: begin
        if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = avm_readdata;
          rsp_error_d = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end

`ifdef AVMM_PIO_MASTER_VERIFY_EN
      S_VRD: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = avm_readdata;
            rsp_error_d = |((avm_readdata ^ writedata_q) & VERIFY_MASK);
          end else begin
            state_d   = S_VWAIT;
            lat_cnt_d = '0;
          end
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
        end else begin
          stall_cnt_d  = stall_cnt_q + STALL_W'(1);
          chipselect_d = 1'b1;
        end
      end

      S_VWAIT: begin
        if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = avm_readdata;
          rsp_error_d = |((avm_readdata ^ writedata_q) & VERIFY_MASK);
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
`endif

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      address_q    <= '0;
      writedata_q  <= '0;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      stall_cnt_q  <= '0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      chipselect_q <= chipselect_d;
      write_n_q    <= write_n_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
      stall_cnt_q  <= stall_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

endmodule

// File: tb/tb_avmm_pio_master.sv
// Bench for avmm_pio_master: two instances (read latency 0 and 2, timeout 4)
// driven by a transaction-level slave and a rule-based response model.
module tb_avmm_pio_master;

  localparam int unsigned NDUT  = 2;
  localparam int unsigned TO    = 4;
  localparam logic [31:0] VMASK = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid       [NDUT];
  logic        cmd_ready       [NDUT];
  logic        cmd_write       [NDUT];
  logic [1:0]  cmd_addr        [NDUT];
  logic [31:0] cmd_wdata       [NDUT];
  logic        rsp_valid       [NDUT];
  logic [31:0] rsp_rdata       [NDUT];
  logic        rsp_error       [NDUT];
  logic [1:0]  avm_address     [NDUT];
  logic        avm_chipselect  [NDUT];
  logic        avm_write_n     [NDUT];
  logic [31:0] avm_writedata   [NDUT];
  logic [31:0] avm_readdata    [NDUT];
  logic        avm_waitrequest [NDUT];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    avmm_pio_master #(
      .READ_LATENCY   ((g == 0) ? 0 : 2),
      .TIMEOUT_CYCLES (TO),
      .VERIFY_MASK    (VMASK)
    ) u_dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid[g]),
      .cmd_ready       (cmd_ready[g]),
      .cmd_write       (cmd_write[g]),
      .cmd_addr        (cmd_addr[g]),
      .cmd_wdata       (cmd_wdata[g]),
      .rsp_valid       (rsp_valid[g]),
      .rsp_rdata       (rsp_rdata[g]),
      .rsp_error       (rsp_error[g]),
      .avm_address     (avm_address[g]),
      .avm_chipselect  (avm_chipselect[g]),
      .avm_write_n     (avm_write_n[g]),
      .avm_writedata   (avm_writedata[g]),
      .avm_readdata    (avm_readdata[g]),
      .avm_waitrequest (avm_waitrequest[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    cmd_valid[k]       = 1'b0;
    cmd_write[k]       = 1'b0;
    cmd_addr[k]        = 2'd0;
    cmd_wdata[k]       = 32'd0;
    avm_readdata[k]    = 32'd0;
    avm_waitrequest[k] = 1'b0;
  endtask

  // One command on DUT k, starting and ending at a negedge. The slave stalls
  // the first 'stalls' chipselect cycles and presents rval exactly 'lat'
  // cycles after the completing read cycle (inverted data at all other times).
  task automatic do_txn(input int k, input bit wr_cmd, input logic [1:0] addr,
                        input logic [31:0] wdata, input int stalls,
                        input logic [31:0] rval, input string tag);
    int          lat;
    bit          tmo;
    int          exp_cs;
    int          exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_wn;
    int          cyc;
    int          cs_seen;
    int          rd_done;
    bit          seen;

    lat = (k == 0) ? 0 : 2;
    tmo = (TO != 0) && (stalls >= int'(TO));
    if (tmo) begin
      exp_cs = int'(TO); exp_rsp = int'(TO) + 1; exp_rdata = 32'd0; exp_err = 1'b1;
    end else if (!wr_cmd) begin
      exp_cs = stalls + 1; exp_rsp = stalls + 2 + lat; exp_rdata = rval; exp_err = 1'b0;
    end else begin
`ifdef AVMM_PIO_MASTER_VERIFY_EN
      exp_cs = stalls + 2; exp_rsp = stalls + 3 + lat; exp_rdata = rval;
      exp_err = (((rval ^ wdata) & VMASK) != 32'd0);
`else
      exp_cs = stalls + 1; exp_rsp = stalls + 2; exp_rdata = 32'd0; exp_err = 1'b0;
`endif
    end

    check({tag, "_ready"}, 32'(cmd_ready[k]), 32'd1);
    cmd_valid[k] = 1'b1;
    cmd_write[k] = wr_cmd;
    cmd_addr[k]  = addr;
    cmd_wdata[k] = wdata;
    @(posedge clk);
    cyc = 0; cs_seen = 0; rd_done = -1; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      // Commands offered while busy must be ignored.
      cmd_valid[k] = 1'($urandom);
      cmd_write[k] = 1'($urandom);
      cmd_addr[k]  = 2'($urandom);
      cmd_wdata[k] = $urandom;
      check({tag, "_cs"}, 32'(avm_chipselect[k]), 32'(cyc <= exp_cs));
      if (avm_chipselect[k]) begin
        cs_seen++;
        check({tag, "_addr"}, 32'(avm_address[k]), 32'(addr));
        check({tag, "_wdata"}, avm_writedata[k], wdata);
        avm_waitrequest[k] = (cs_seen <= stalls);
        if (avm_write_n[k] && !avm_waitrequest[k]) rd_done = cyc;
      end else begin
        avm_waitrequest[k] = 1'($urandom);
      end
      exp_wn = !(wr_cmd && avm_chipselect[k] && (tmo || cs_seen <= stalls + 1));
      check({tag, "_write_n"}, 32'(avm_write_n[k]), 32'(exp_wn));
      avm_readdata[k] = (rd_done >= 0 && cyc == rd_done + lat) ? rval : ~rval;
      if (rsp_valid[k]) begin
        seen = 1'b1;
        check({tag, "_rsp_cycle"}, 32'(cyc), 32'(exp_rsp));
        check({tag, "_rdata"}, rsp_rdata[k], exp_rdata);
        check({tag, "_error"}, 32'(rsp_error[k]), 32'(exp_err));
        cmd_valid[k] = 1'b0;
      end
    end
    if (!seen) check({tag, "_rsp_missing"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, 32'(rsp_valid[k]), 32'd0);
    check({tag, "_ready_again"}, 32'(cmd_ready[k]), 32'd1);
    idle_inputs(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [31:0] r;
    int          k;
    reset = 1'b1;
    for (int i = 0; i < int'(NDUT); i++) idle_inputs(i);
    repeat (3) @(negedge clk);
    for (int i = 0; i < int'(NDUT); i++) begin
      check("rst_cs", 32'(avm_chipselect[i]), 32'd0);
      check("rst_wn", 32'(avm_write_n[i]), 32'd1);
      check("rst_addr", 32'(avm_address[i]), 32'd0);
      check("rst_wdata", avm_writedata[i], 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rdata", rsp_rdata[i], 32'd0);
      check("rst_err", 32'(rsp_error[i]), 32'd0);
      check("rst_ready", 32'(cmd_ready[i]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    do_txn(0, 1'b1, 2'd0, 32'h0000_00A5, 0, 32'h0000_00A5, "wr_a5");
    do_txn(0, 1'b0, 2'd0, 32'h0000_0000, 0, 32'h0000_00A5, "rd_a5");
    do_txn(1, 1'b0, 2'd1, 32'h0BAD_F00D, 3, 32'h0000_003C, "rd_lat2_stall3");
    do_txn(0, 1'b1, 2'd3, 32'hDEAD_BEEF, 6, 32'h0, "wr_timeout");
    do_txn(0, 1'b0, 2'd2, 32'h1111_2222, 0, 32'h7777_8888, "rd_after_tmo");
    do_txn(0, 1'b1, 2'd2, 32'h5555_AAAA, 3, 32'h5555_AAAA, "wr_stall_edge");
    do_txn(1, 1'b0, 2'd3, 32'h0, 4, 32'h1234_0000, "rd_timeout_lat2");
    do_txn(1, 1'b0, 2'd0, 32'h0, 3, 32'hCAFE_0001, "rd_edge_lat2");
    do_txn(1, 1'b1, 2'd1, 32'h0F0F_0F0F, 0, 32'h0F0F_0F0F, "wr_lat2");
`ifdef AVMM_PIO_MASTER_VERIFY_EN
    do_txn(0, 1'b1, 2'd0, 32'h1234_5678, 0, 32'h0000_0078, "vfy_ok");
    do_txn(0, 1'b1, 2'd0, 32'h1234_5678, 0, 32'h0000_0070, "vfy_bad");
    do_txn(1, 1'b1, 2'd2, 32'h1234_5678, 1, 32'hFFFF_FF78, "vfy_ok_lat2");
`endif

    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 1));
      w = $urandom;
      r = ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 65535), w[15:0]} : $urandom;
      do_txn(k, 1'($urandom), 2'($urandom), w,
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0, r, "rand");
    end

    // Reset during a stalled read drops it without a response.
    cmd_valid[1] = 1'b1; cmd_write[1] = 1'b0; cmd_addr[1] = 2'd2; cmd_wdata[1] = 32'h99;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    avm_waitrequest[1] = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_before", 32'(avm_chipselect[1]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cs", 32'(avm_chipselect[1]), 32'd0);
    check("mid_rst_wn", 32'(avm_write_n[1]), 32'd1);
    check("mid_rst_rsp", 32'(rsp_valid[1]), 32'd0);
    check("mid_rst_ready_low", 32'(cmd_ready[1]), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready[1]), 32'd1);
      check("post_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
      check("post_rst_cs", 32'(avm_chipselect[1]), 32'd0);
    end
    idle_inputs(1);
    do_txn(1, 1'b0, 2'd1, 32'h0, 0, 32'hA5A5_0001, "rd_post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
